// File: rtl/pc_unit.sv
// Program-counter stage: holds the architectural PC, selects the next PC,
// counts retired instructions and latches self-loop halt / misaligned-JR fault.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal fetch; PC advances whenever enable_i is high
// ST_HALTED  | self-loop seen; everything frozen until reset
// ST_FAULT   | JR to a non-word-aligned target; everything frozen until reset
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [1:0]  pcsel_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] jaddr_i,
  input  logic [31:0] reg_rs_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_count_o,
  output logic        halted_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        advance;
  logic        jr_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign advance       = enable_i && (state_q == ST_RUN);
  assign jr_misaligned = (pcsel_i == 2'b11) && (reg_rs_i[1:0] != 2'b00);

  always_comb begin
    npc = pc_plus4;
    unique case (pcsel_i)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + {{14{imm_i[15]}}, imm_i, 2'b00};
      2'b10: npc = {pc_plus4[31:28], jaddr_i, 2'b00};
      2'b11: npc = reg_rs_i;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (advance) begin
      // A misaligned JR neither retires nor moves the PC.
      if (jr_misaligned) begin
        state_d = ST_FAULT;
      end else begin
        pc_d  = npc;
        cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        if (HALT_DETECT && (npc == pc_q)) begin
          state_d = ST_HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign instr_count_o = cnt_q;
  assign halted_o      = (state_q == ST_HALTED);
  assign misalign_o    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed vectors push expected post-edge state,
// an independent monitor pops and compares after every rising edge.
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [1:0]  pcsel_i;
  logic [15:0] imm_i;
  logic [25:0] jaddr_i;
  logic [31:0] reg_rs_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_count_o;
  logic        halted_o;
  logic        misalign_o;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        misalign;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_unit #(.RESET_PC(32'h0040_0000), .HALT_DETECT(1'b1)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .pcsel_i      (pcsel_i),
    .imm_i        (imm_i),
    .jaddr_i      (jaddr_i),
    .reg_rs_i     (reg_rs_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .instr_count_o(instr_count_o),
    .halted_o     (halted_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: state is stable #1 after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk32({e.name, " pc"},       pc_o,          e.pc);
        chk32({e.name, " pc_plus4"}, pc_plus4_o,    e.pc + 32'd4);
        chk32({e.name, " count"},    instr_count_o, e.cnt);
        chk32({e.name, " halted"},   {31'd0, halted_o},   {31'd0, e.halted});
        chk32({e.name, " misalign"}, {31'd0, misalign_o}, {31'd0, e.misalign});
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic en,
                      input logic [1:0] sel, input logic [15:0] imm,
                      input logic [25:0] ja, input logic [31:0] rs,
                      input logic [31:0] epc, input logic [31:0] ecnt,
                      input logic eh, input logic em);
    exp_t e;
    @(negedge clk_i);
    reset_i  = rst;
    enable_i = en;
    pcsel_i  = sel;
    imm_i    = imm;
    jaddr_i  = ja;
    reg_rs_i = rs;
    e.name = nm; e.pc = epc; e.cnt = ecnt; e.halted = eh; e.misalign = em;
    exp_q.push_back(e);
  endtask

  initial begin
    int budget;
    reset_i = 1'b1; enable_i = 1'b0; pcsel_i = 2'b00;
    imm_i = '0; jaddr_i = '0; reg_rs_i = '0;

    step("reset",   1, 0, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0000, 0, 0, 0);
    step("seq1",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0004, 1, 0, 0);
    step("seq2",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0008, 2, 0, 0);
    step("seq3",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_000C, 3, 0, 0);
    step("seq4",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0010, 4, 0, 0);
    step("br_back", 0, 1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 32'h0040_000C, 5, 0, 0);
    step("br_fwd",  0, 1, 2'b01, 16'h0003, 26'h0, 32'h0, 32'h0040_001C, 6, 0, 0);
    step("seq5",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0020, 7, 0, 0);
    step("jump",    0, 1, 2'b10, 16'h0, 26'h010_0040, 32'h0, 32'h0040_0100, 8, 0, 0);
    step("jr",      0, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0200, 32'h0040_0200, 9, 0, 0);
    for (int i = 0; i < 5; i++)
      step("disabled", 0, 0, 2'(i % 4), 16'h0001, 26'h3FF_FFFF, 32'h0000_1000,
           32'h0040_0200, 9, 0, 0);
    step("jr_top",  0, 1, 2'b11, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 10, 0, 0);
    step("wrap",    0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0000, 11, 0, 0);
    step("post_wrap", 0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0004, 12, 0, 0);
    step("jr_misal", 0, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0202, 32'h0000_0004, 12, 0, 1);
    step("fault_seq", 0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0000_0004, 12, 0, 1);
    step("fault_j", 0, 1, 2'b10, 16'h0, 26'h010_0040, 32'h0, 32'h0000_0004, 12, 0, 1);
    step("fault_jr", 0, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0200, 32'h0000_0004, 12, 0, 1);
    step("reset2",  1, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0202, 32'h0040_0000, 0, 0, 0);
    step("jr_30",   0, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0030, 32'h0040_0030, 1, 0, 0);
    step("halt",    0, 1, 2'b01, 16'hFFFF, 26'h0, 32'h0, 32'h0040_0030, 2, 1, 0);
    step("halt_seq", 0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0030, 2, 1, 0);
    step("halt_jr", 0, 1, 2'b11, 16'h0, 26'h0, 32'h0040_0202, 32'h0040_0030, 2, 1, 0);
    step("reset3",  1, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0000, 0, 0, 0);
    step("seq_after", 0, 1, 2'b00, 16'h0, 26'h0, 32'h0, 32'h0040_0004, 1, 0, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS datapath. Sits directly downstream of the controller and consumes its pcsel output.
- Holds the architectural PC and computes the next PC: sequential, branch, jump or jump-register.
- Supplies pc to instruction memory and pc_plus4 to the register-file write-data mux (JAL link).
- Adds a retired-instruction counter, halt detection (jump/branch to self) and a sticky misaligned-JR fault.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset (word aligned).
- HALT_DETECT, 1, 1 = enable self-loop halt detection; 0 = never assert halted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  processor enable, same signal the controller receives.
- pcsel  input  2  from controller: 00 = pc+4, 01 = branch, 10 = J/JAL, 11 = JR.
- imm  input  16  instr[15:0], branch offset in words.
- jaddr  input  26  instr[25:0], jump target field.
- reg_rs  input  32  register-file read data for rs (JR target).
- pc  output  32  current PC, registered.
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32.
- instr_count  output  32  retired-instruction count, registered.
- halted  output  1  sticky: self-loop detected.
- misalign  output  1  sticky: JR target not word aligned.

Behaviour:
- The design has one clock and one reset. Reset is synchronous and active-high and has priority over every other input.
- Reset values: pc = RESET_PC, instr_count = 0, halted = 0, misalign = 0.
- Next-PC computation (combinational, all arithmetic 32-bit, modulo 2^32):
  - 00: npc = pc_plus4.
  - 01: npc = pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
  - 10: npc = {pc_plus4[31:28], jaddr, 2'b00}.
  - 11: npc = reg_rs.
- Define advance = enable & ~halted & ~misalign.
- States are implicit: RUN, HALTED, FAULT.
  - RUN → HALTED when halted is set.
  - RUN → FAULT when misalign is set.
  - HALTED and FAULT exit only via reset.
- On a clock edge with advance = 1:
  - If pcsel = 11 and reg_rs[1:0] != 0: misalign <= 1, pc holds, instr_count holds.
  - Otherwise: pc <= npc, and instr_count <= instr_count + 1, saturating at 32'hFFFF_FFFF.
  - If additionally HALT_DETECT = 1 and npc == pc: halted <= 1. The self-loop instruction is counted; pc is unchanged by construction.
- On a clock edge with advance = 0: pc, instr_count, halted and misalign all hold.
- Only pcsel = 11 is checked for alignment. Branch and jump targets are aligned by construction.
- Simultaneous misalign and self-loop (JR to its own misaligned address) is impossible because pc is always aligned; misalign wins in any case.
- pc+4 at 32'hFFFF_FFFC wraps to 0. Branch targets wrap the same way. No fault is raised for wrap.
- Reset mid-run, including while halted or faulted: the next edge restores the reset values. instr_count does not survive reset.
- Latency: pc changes one edge after the controller presents pcsel. pc_plus4 tracks pc within the same cycle.

Test Plan:
- Reset → sequential: reset high 1 edge, then enable=1, pcsel=00 for 3 edges → pc = 0040_0000, 0040_0004, 0040_0008, 0040_000C; instr_count = 3.
- Branch: pc=0040_0010, pcsel=01, imm=16'hFFFE → pc = 0040_000C. Then imm=16'h0003 → pc = 0040_001C.
- Jump/JR: pc=0040_0020, pcsel=10, jaddr=26'h010_0040 → pc = 0040_0100. Then pcsel=11, reg_rs=0040_0200 → pc = 0040_0200.
- Misaligned JR: pcsel=11, reg_rs=0040_0202 → misalign=1, pc and instr_count frozen on following edges regardless of pcsel.
- Halt: pc=0040_0030, pcsel=01, imm=16'hFFFF → halted=1, pc stays 0040_0030, count increments once then freezes. Reset clears halted and pc=0040_0000.
- Enable/wrap: enable=0 for 5 edges → no state change. pc forced via JR to FFFF_FFFC then pcsel=00 → pc = 0000_0000, no fault.
